// File: rtl/mu0_mux_pkg.sv
// Shared constants and helpers for the MU0 arbitrated multiplexer.
// Mode encodings, default geometry and the index-width helper live here
// so the interface, arbiter and top agree on them.
package mu0_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_W = 12;
    localparam int DEF_N = 4;

    // Ceiling log2, never less than 1 so a 2-channel mux still has a select bit.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((32'sd1 <<< res) < value) begin
            res = res + 1;
        end
        if (res < 1) begin
            res = 1;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/mu0_arb_mux_if.sv
// Handshake bundle for mu0_arb_mux: N input channels, one output channel,
// plus the Mode/Sel controls. The slave modport is the mux side.
// Optional MU0_ARB_MUX_PARITY_EN adds the Out_Par output.
interface mu0_arb_mux_if
    import mu0_mux_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
);
    localparam int CW = clog2(N);

    logic [N*W-1:0] In_Data;
    logic [N-1:0]   In_Valid;
    logic [N-1:0]   In_Ready;
    logic           Mode;
    logic [CW-1:0]  Sel;
    logic [W-1:0]   Out_Data;
    logic [CW-1:0]  Out_Chan;
    logic           Out_Valid;
    logic           Out_Ready;
`ifdef MU0_ARB_MUX_PARITY_EN
    logic           Out_Par;
`endif

    modport slave (
`ifdef MU0_ARB_MUX_PARITY_EN
        output Out_Par,
`endif
        input  In_Data, In_Valid, Mode, Sel, Out_Ready,
        output In_Ready, Out_Data, Out_Chan, Out_Valid
    );

    modport master (
`ifdef MU0_ARB_MUX_PARITY_EN
        input  Out_Par,
`endif
        output In_Data, In_Valid, Mode, Sel, Out_Ready,
        input  In_Ready, Out_Data, Out_Chan, Out_Valid
    );

endinterface

// File: rtl/mu0_rr_arbiter.sv
// Round-robin scan: first requesting channel at or after ptr, wrapping
// at N-1 -> 0. Purely combinational; the pointer is owned by the caller.
module mu0_rr_arbiter
    import mu0_mux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] idx
);

    logic found_s;
    int   pos_s;

    // Scan from ptr upward and grant the first requester only.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int k = 0; k < N; k++) begin
            pos_s = (int'(ptr) + k) % N;
            if (enable && !found_s && req[pos_s]) begin
                grant[pos_s] = 1'b1;
                idx          = CW'(pos_s);
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mu0_arb_mux.sv
// N-channel, W-bit mux with a single registered output stage and
// valid/ready on every port. Mode 0 uses Sel directly, Mode 1 arbitrates
// round-robin. Optional macro: MU0_ARB_MUX_PARITY_EN (adds Out_Par).
module mu0_arb_mux
    import mu0_mux_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input logic         Clk,
    input logic         Reset,
    mu0_arb_mux_if.slave bus
);

    localparam int CW = clog2(N);

    logic [W-1:0]  out_data_r;
    logic [CW-1:0] out_chan_r;
    logic          out_valid_r;
    logic [CW-1:0] ptr_r;

    logic          can_load_s;
    logic          sel_ok_s;
    logic [N-1:0]  fix_grant_s;
    logic [N-1:0]  rr_grant_s;
    logic [CW-1:0] rr_idx_s;
    logic [N-1:0]  grant_s;
    logic [CW-1:0] grant_idx_s;
    logic [W-1:0]  grant_data_s;
    logic [CW-1:0] next_ptr_s;

`ifdef MU0_ARB_MUX_PARITY_EN
    logic          out_par_r;

    // Even parity of a data word (XOR reduction).
    function automatic logic even_parity(input logic [W-1:0] d);
        return ^d;
    endfunction
`endif

    // Gating on Reset keeps every In_Ready low during the reset cycle.
    assign can_load_s = (!out_valid_r || bus.Out_Ready) && !Reset;
    assign sel_ok_s   = (int'(32'(bus.Sel)) < N);

    mu0_rr_arbiter #(.N(N), .CW(CW)) u_rr (
        .req    (bus.In_Valid),
        .ptr    (ptr_r),
        .enable (can_load_s && (bus.Mode == MODE_RR)),
        .grant  (rr_grant_s),
        .idx    (rr_idx_s)
    );

    // Fixed-select grant; an out-of-range Sel grants nothing.
    always_comb begin
        fix_grant_s = '0;
        if ((bus.Mode == MODE_FIXED) && sel_ok_s && can_load_s && bus.In_Valid[bus.Sel]) begin
            fix_grant_s[bus.Sel] = 1'b1;
        end else begin
            fix_grant_s = '0;
        end
    end

    // Merge the two grant sources and pick the winning word.
    always_comb begin
        grant_s      = '0;
        grant_idx_s  = '0;
        grant_data_s = '0;
        if (bus.Mode == MODE_RR) begin
            grant_s     = rr_grant_s;
            grant_idx_s = rr_idx_s;
        end else begin
            grant_s     = fix_grant_s;
            grant_idx_s = bus.Sel;
        end
        if (|grant_s) begin
            grant_data_s = bus.In_Data[int'(grant_idx_s)*W +: W];
        end else begin
            grant_data_s = '0;
        end
    end

    // Pointer advances past the granted channel, wrapping to 0.
    always_comb begin
        next_ptr_s = '0;
        if (int'(32'(rr_idx_s)) >= (N - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = rr_idx_s + CW'(1);
        end
    end

    // Output register and RR pointer: load on grant, drain when accepted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_data_r  <= '0;
            out_chan_r  <= '0;
            out_valid_r <= 1'b0;
            ptr_r       <= '0;
`ifdef MU0_ARB_MUX_PARITY_EN
            out_par_r   <= 1'b0;
`endif
        end else if (|grant_s) begin
            out_data_r  <= grant_data_s;
            out_chan_r  <= grant_idx_s;
            out_valid_r <= 1'b1;
`ifdef MU0_ARB_MUX_PARITY_EN
            out_par_r   <= even_parity(grant_data_s);
`endif
            if (bus.Mode == MODE_RR) begin
                ptr_r <= next_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (out_valid_r && bus.Out_Ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.In_Ready  = grant_s;
    assign bus.Out_Data  = out_data_r;
    assign bus.Out_Chan  = out_chan_r;
    assign bus.Out_Valid = out_valid_r;
`ifdef MU0_ARB_MUX_PARITY_EN
    assign bus.Out_Par   = out_par_r;
`endif

endmodule

// File: tb/tb_mu0_arb_mux.sv
// Directed self-checking bench for mu0_arb_mux (W=12, N=4).
module tb_mu0_arb_mux;
    import mu0_mux_pkg::*;

    localparam int W = 12;
    localparam int N = 4;

    logic Clk;
    logic Reset;
    int   chk_cnt;
    int   pass_cnt;

    mu0_arb_mux_if #(.W(W), .N(N)) bus ();

    mu0_arb_mux #(.W(W), .N(N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        Reset         = 1'b1;
        bus.In_Data   = {12'h333, 12'hABC, 12'h222, 12'h111};
        bus.In_Valid  = 4'b1111;
        bus.Mode      = MODE_FIXED;
        bus.Sel       = 2'd0;
        bus.Out_Ready = 1'b1;

        // Reset with everything valid
        tick();
        tick();
        check_val("rst_valid", 32'(bus.Out_Valid), 32'h0);
        check_val("rst_data",  32'(bus.Out_Data),  32'h0);
        check_val("rst_chan",  32'(bus.Out_Chan),  32'h0);
        check_val("rst_ready", 32'(bus.In_Ready),  32'h0);
`ifdef MU0_ARB_MUX_PARITY_EN
        check_val("rst_par",   32'(bus.Out_Par),   32'h0);
`endif
        Reset = 1'b0;
        #1;
        check_val("post_rst_ready", 32'(bus.In_Ready), 32'h1);
        tick();
        check_val("post_rst_valid", 32'(bus.Out_Valid), 32'h1);
        check_val("post_rst_data",  32'(bus.Out_Data),  32'h111);

        // Fixed select, Sel=2
        bus.Sel      = 2'd2;
        bus.In_Valid = 4'b0100;
        #1;
        check_val("fix2_ready", 32'(bus.In_Ready), 32'h4);
        tick();
        check_val("fix2_data", 32'(bus.Out_Data), 32'hABC);
        check_val("fix2_chan", 32'(bus.Out_Chan), 32'h2);

        // Fixed select on an idle channel: no grant, output drains
        bus.Sel = 2'd3;
        #1;
        check_val("fix3_ready", 32'(bus.In_Ready), 32'h0);
        tick();
        check_val("fix3_drain", 32'(bus.Out_Valid), 32'h0);

        // Round-robin, all valid, full throughput
        bus.Mode     = MODE_RR;
        bus.In_Valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val($sformatf("rr_chan%0d", i), 32'(bus.Out_Chan), 32'(i % 4));
            check_val($sformatf("rr_valid%0d", i), 32'(bus.Out_Valid), 32'h1);
        end
        check_val("rr_last_data", 32'(bus.Out_Data), 32'h333);

        // Backpressure: output frozen, no grant
        bus.Out_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("stall_ready%0d", i), 32'(bus.In_Ready), 32'h0);
            tick();
            check_val($sformatf("stall_data%0d", i), 32'(bus.Out_Data), 32'h333);
            check_val($sformatf("stall_chan%0d", i), 32'(bus.Out_Chan), 32'h3);
        end
        bus.Out_Ready = 1'b1;
        #1;
        check_val("unstall_ready", 32'(bus.In_Ready), 32'h1);
        tick();
        check_val("unstall_chan",  32'(bus.Out_Chan),  32'h0);
        check_val("unstall_valid", 32'(bus.Out_Valid), 32'h1);
        check_val("unstall_data",  32'(bus.Out_Data),  32'h111);

        // Grant ch3 then wrap to ch0
        bus.In_Valid = 4'b1000;
        #1;
        check_val("ch3_ready", 32'(bus.In_Ready), 32'h8);
        tick();
        check_val("ch3_chan", 32'(bus.Out_Chan), 32'h3);
        bus.In_Valid = 4'b0001;
        #1;
        check_val("wrap_ready", 32'(bus.In_Ready), 32'h1);
        tick();
        check_val("wrap_chan", 32'(bus.Out_Chan), 32'h0);

        // Fixed detour leaves the RR pointer at 1
        bus.Mode     = MODE_FIXED;
        bus.Sel      = 2'd1;
        bus.In_Valid = 4'b0011;
        #1;
        check_val("detour_ready", 32'(bus.In_Ready), 32'h2);
        tick();
        check_val("detour_chan", 32'(bus.Out_Chan), 32'h1);
        bus.Mode     = MODE_RR;
        bus.In_Valid = 4'b1111;
        #1;
        check_val("resume_ready", 32'(bus.In_Ready), 32'h2);
        tick();
        check_val("resume_chan", 32'(bus.Out_Chan), 32'h1);
        check_val("resume_data", 32'(bus.Out_Data), 32'h222);

        // Idle: output drains
        bus.In_Valid = 4'b0000;
        tick();
        check_val("idle_valid", 32'(bus.Out_Valid), 32'h0);

`ifdef MU0_ARB_MUX_PARITY_EN
        // Parity of loaded words and hold under stall
        bus.Mode     = MODE_FIXED;
        bus.Sel      = 2'd0;
        bus.In_Data  = {12'h333, 12'hABC, 12'h222, 12'h007};
        bus.In_Valid = 4'b0001;
        tick();
        check_val("par_007", 32'(bus.Out_Par), 32'h1);
        bus.In_Data = {12'h333, 12'hABC, 12'h222, 12'h003};
        tick();
        check_val("par_003", 32'(bus.Out_Par), 32'h0);
        bus.Out_Ready = 1'b0;
        bus.In_Data   = {12'h333, 12'hABC, 12'h222, 12'h007};
        tick();
        tick();
        check_val("par_hold", 32'(bus.Out_Par), 32'h0);
        check_val("par_hold_data", 32'(bus.Out_Data), 32'h003);
        bus.Out_Ready = 1'b1;
        bus.In_Valid  = 4'b0000;
        tick();
`endif

        // Reset mid-transfer discards the held word
        bus.Mode     = MODE_RR;
        bus.In_Valid = 4'b1111;
        tick();
        check_val("pre_rst2_valid", 32'(bus.Out_Valid), 32'h1);
        Reset = 1'b1;
        #1;
        check_val("rst2_ready", 32'(bus.In_Ready), 32'h0);
        tick();
        check_val("rst2_valid", 32'(bus.Out_Valid), 32'h0);
        check_val("rst2_data",  32'(bus.Out_Data),  32'h0);
        Reset = 1'b0;
        tick();
        check_val("rst2_ptr_chan", 32'(bus.Out_Chan), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mu0_arb_mux.md
Name: mu0_arb_mux

Overview:
- Parametrised N-channel, W-bit multiplexer with one registered output stage and valid/ready handshakes on every input and on the output.
- Mode input selects the channel source:
  - fixed select: Sel chooses the channel, as the plain 2:1 mux does;
  - round-robin arbitration across all channels.
- Sits between MU0 datapath sources (PC, IR operand, ALU result, memory read) and shared consumers (address bus, accumulator load), replacing hand-instantiated 12-bit 2:1 muxes.

Parameters:
- W, 12, data width in bits (>=1).
- N, 4, channel count (>=2).
- CW, $clog2(N), channel index width (derived; not overridden).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- In_Data  input  N*W  channel i occupies bits [i*W +: W].
- In_Valid  input  N  channel i has data.
- In_Ready  output  N  one-hot (or zero) grant; channel i transfers when In_Valid[i] & In_Ready[i].
- Mode  input  1  0 = fixed select, 1 = round-robin.
- Sel  input  CW  channel index used when Mode = 0.
- Out_Data  output  W  registered selected data.
- Out_Chan  output  CW  registered index of the source channel.
- Out_Valid  output  1  output register holds data.
- Out_Ready  input  1  consumer accepts.

Behaviour:
- Reset (synchronous, Reset=1 at a rising Clk edge):
  - Out_Valid=0, Out_Data=0, Out_Chan=0.
  - RR pointer=0, so channel 0 has highest priority on the first RR grant.
  - In_Ready is combinational and therefore 0 while Out_Valid=0 and no input is valid.
- Reset mid-transfer discards any held word; no In_Ready is asserted during the reset cycle.
- Accept condition: can_load = !Out_Valid | Out_Ready.
- Grant, combinational from current inputs:
  - Mode=0: grant[Sel] = In_Valid[Sel] & can_load; all other bits 0.
  - Mode=0 with Sel >= N (N not a power of 2): no grant.
  - Mode=1: first valid channel scanning ptr, ptr+1, ..., wrapping at N-1 -> 0; grant only if can_load.
- In_Ready = grant. At most one bit is set. In_Ready never depends on In_Valid of the granted channel's own handshake loop beyond the arbitration scan.
- On a clock edge with any grant bit set:
  - Out_Data <= selected channel data; Out_Chan <= granted index; Out_Valid <= 1.
  - Mode=1 only: ptr <= (granted index + 1) mod N.
- On a clock edge with no grant and Out_Valid & Out_Ready: Out_Valid <= 0.
- Simultaneous drain and load: Out_Valid stays 1 and the new word replaces the old one. This gives full throughput of 1 word/cycle.
- Latency: exactly 1 cycle from the input handshake to Out_Valid.
- Output stability: while Out_Valid & !Out_Ready, Out_Data and Out_Chan hold unchanged and In_Ready=0.
- Mode or Sel changes:
  - take effect in the same cycle's grant;
  - never alter the held output;
  - ptr is retained across Mode=0 periods.
- No X outputs after reset for any Sel value.

Optional Feature:
- Macro: MU0_ARB_MUX_PARITY_EN.
- Defined:
  - adds output Out_Par (1 bit), registered with Out_Data, equal to the even parity (XOR reduction) of the loaded word;
  - reset value 0;
  - held stable under backpressure like Out_Data.
- Undefined: port absent; no parity logic.

Decomposition:
- Package mu0_mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1;
  - default W=12 and N=4 constants;
  - function clog2 for CW.
- Sub-module mu0_rr_arbiter (parameter N):
  - inputs: req[N], ptr, enable;
  - outputs: one-hot grant and encoded index.
  - Used for Mode=1. The fixed-select path and output register stay in mu0_arb_mux.

Test Plan:
- Reset with all In_Valid=1 and Out_Ready=1 -> Out_Valid=0, Out_Data=0, Out_Chan=0, In_Ready=0000 during reset; Out_Valid=1 on the first cycle after reset deasserts.
- Mode=0, Sel=2, In_Valid=0100, ch2 data=12'hABC, Out_Ready=1 -> In_Ready=0100, next cycle Out_Data=12'hABC, Out_Chan=2. With Sel=3 and In_Valid=0100 -> In_Ready=0000, Out_Valid drops after the drain.
- Mode=1, In_Valid=1111 held, Out_Ready=1 for 8 cycles -> Out_Chan sequence 0,1,2,3,0,1,2,3 with Out_Valid continuously 1.
- Mode=1, Out_Ready=0 for 3 cycles with Out_Valid=1 -> In_Ready=0000, Out_Data frozen. Raise Out_Ready -> back-to-back transfer in the same edge, no bubble.
- Mode=1 after grant to ch3, then In_Valid=0001 -> grant ch0 (wrap). Switch to Mode=0 with Sel=1, In_Valid=0011 -> grant ch1. Return to Mode=1 -> scan resumes from ptr=1.
- With MU0_ARB_MUX_PARITY_EN defined: load 12'h007 -> Out_Par=1; load 12'h003 -> Out_Par=0; Out_Par holds while stalled.
